// File: rtl/pipe_wb_stage_reg.sv
// rtl/pipe_wb_stage_reg.sv - Y86-64 memory-to-writeback pipeline register
// Adds stall/bubble control, halt-freeze, valid flag, stall counter and protocol-error flag.
module pipe_wb_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter int                 NUM_VAL   = 2,
    parameter int                 STAT_W    = 3,
    parameter int                 ICODE_W   = 4,
    parameter int                 REG_W     = 4,
    parameter logic [STAT_W-1:0]  STAT_AOK  = 3'd1,
    parameter logic [ICODE_W-1:0] ICODE_NOP = 4'h1,
    parameter logic [REG_W-1:0]   REG_NONE  = 4'hF,
    parameter int                 CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      bubble,
    input  logic [STAT_W-1:0]         in_stat,
    input  logic [ICODE_W-1:0]        in_icode,
    input  logic [NUM_VAL*DATA_W-1:0] in_val,
    input  logic [REG_W-1:0]          in_dstE,
    input  logic [REG_W-1:0]          in_dstM,
    output logic [STAT_W-1:0]         out_stat,
    output logic [ICODE_W-1:0]        out_icode,
    output logic [NUM_VAL*DATA_W-1:0] out_val,
    output logic [REG_W-1:0]          out_dstE,
    output logic [REG_W-1:0]          out_dstM,
    output logic                      out_valid,
    output logic                      halted,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic                      proto_err
);

    localparam int VAL_W = NUM_VAL * DATA_W;

    logic [STAT_W-1:0]  r_stat;
    logic [ICODE_W-1:0] r_icode;
    logic [VAL_W-1:0]   r_val;
    logic [REG_W-1:0]   r_dst_e;
    logic [REG_W-1:0]   r_dst_m;
    logic               r_valid;
    logic               r_halted;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat      <= STAT_AOK;
            r_icode     <= ICODE_NOP;
            r_val       <= '0;
            r_dst_e     <= REG_NONE;
            r_dst_m     <= REG_NONE;
            r_valid     <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
            r_proto_err <= 1'b0;
        end else begin
            // The conflict is recorded even while frozen by a halt.
            if (stall && bubble) begin
                r_proto_err <= 1'b1;
            end
            if (!r_halted) begin
                if (stall) begin
                    if (r_stall_cnt != {CNT_W{1'b1}}) begin
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                    end
                end else if (bubble) begin
                    r_stat  <= STAT_AOK;
                    r_icode <= ICODE_NOP;
                    r_val   <= '0;
                    r_dst_e <= REG_NONE;
                    r_dst_m <= REG_NONE;
                    r_valid <= 1'b0;
                end else begin
                    r_stat  <= in_stat;
                    r_icode <= in_icode;
                    r_val   <= in_val;
                    r_dst_e <= in_dstE;
                    r_dst_m <= in_dstM;
                    r_valid <= 1'b1;
                    if (in_stat != STAT_AOK) begin
                        r_halted <= 1'b1;
                    end
                end
            end
        end
    end

    assign out_stat  = r_stat;
    assign out_icode = r_icode;
    assign out_val   = r_val;
    assign out_dstE  = r_dst_e;
    assign out_dstM  = r_dst_m;
    assign out_valid = r_valid;
    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_pipe_wb_stage_reg.sv
// tb/tb_pipe_wb_stage_reg.sv - directed self-checking bench for pipe_wb_stage_reg
module tb_pipe_wb_stage_reg;

    localparam int CNT_W = 4;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         bubble;
    logic [2:0]   in_stat;
    logic [3:0]   in_icode;
    logic [127:0] in_val;
    logic [3:0]   in_dstE;
    logic [3:0]   in_dstM;
    logic [2:0]   out_stat;
    logic [3:0]   out_icode;
    logic [127:0] out_val;
    logic [3:0]   out_dstE;
    logic [3:0]   out_dstM;
    logic         out_valid;
    logic         halted;
    logic [3:0]   stall_cnt;
    logic         proto_err;

    int checks;
    int failures;

    pipe_wb_stage_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_val(in_val),
        .in_dstE(in_dstE), .in_dstM(in_dstM),
        .out_stat(out_stat), .out_icode(out_icode), .out_val(out_val),
        .out_dstE(out_dstE), .out_dstM(out_dstM), .out_valid(out_valid),
        .halted(halted), .stall_cnt(stall_cnt), .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        in_stat  = s;
        in_icode = ic;
        in_val   = {vm, ve};
        in_dstE  = de;
        in_dstM  = dm;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (out_stat !== 3'd1) begin failures++; $display("FAIL reset_stat got=%0h exp=1", out_stat); end
        checks++; if (out_icode !== 4'h1) begin failures++; $display("FAIL reset_icode got=%0h exp=1", out_icode); end
        checks++; if (out_val !== 128'h0) begin failures++; $display("FAIL reset_val got=%0h exp=0", out_val); end
        checks++; if ({out_dstE, out_dstM} !== 8'hFF) begin failures++; $display("FAIL reset_dst got=%0h exp=ff", {out_dstE, out_dstM}); end
        checks++; if ({out_valid, halted, proto_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {out_valid, halted, proto_err}); end
        checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load();
        drive(3'd1, 4'h6, 64'h10, 64'h20, 4'h3, 4'hF);
        tick();
        checks++; if (out_stat !== 3'd1 || out_icode !== 4'h6) begin failures++; $display("FAIL load_stat_icode got=%0h/%0h exp=1/6", out_stat, out_icode); end
        checks++; if (out_val !== {64'h20, 64'h10}) begin failures++; $display("FAIL load_val got=%0h exp=%0h", out_val, {64'h20, 64'h10}); end
        checks++; if ({out_dstE, out_dstM} !== 8'h3F) begin failures++; $display("FAIL load_dst got=%0h exp=3f", {out_dstE, out_dstM}); end
        checks++; if (out_valid !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL load_valid got=%b%b exp=10", out_valid, halted); end
    endtask

    task automatic test_stall();
        drive(3'd1, 4'h5, 64'h0, 64'hDEAD, 4'h4, 4'h5);
        tick();
        stall = 1'b1;
        drive(3'd1, 4'h2, 64'h0, 64'h0, 4'h6, 4'h7);
        repeat (3) tick();
        checks++; if (out_icode !== 4'h5 || out_val[127:64] !== 64'hDEAD) begin failures++; $display("FAIL stall_hold got=%0h/%0h exp=5/dead", out_icode, out_val[127:64]); end
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
        stall = 1'b0;
        tick();
        checks++; if (out_icode !== 4'h2 || out_val[127:64] !== 64'h0 || out_dstE !== 4'h6) begin failures++; $display("FAIL stall_release got=%0h/%0h/%0h exp=2/0/6", out_icode, out_val[127:64], out_dstE); end
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL stall_cnt_after got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_bubble();
        drive(3'd1, 4'h6, 64'h1234, 64'h5678, 4'h2, 4'h3);
        tick();
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        checks++; if (out_stat !== 3'd1 || out_icode !== 4'h1) begin failures++; $display("FAIL bubble_stat_icode got=%0h/%0h exp=1/1", out_stat, out_icode); end
        checks++; if (out_val !== 128'h0) begin failures++; $display("FAIL bubble_val got=%0h exp=0", out_val); end
        checks++; if ({out_dstE, out_dstM} !== 8'hFF || out_valid !== 1'b0) begin failures++; $display("FAIL bubble_dst_valid got=%0h/%b exp=ff/0", {out_dstE, out_dstM}, out_valid); end
    endtask

    task automatic test_halt();
        drive(3'd2, 4'h0, 64'hAA, 64'hBB, 4'hF, 4'hF);
        tick();
        checks++; if (halted !== 1'b1 || out_stat !== 3'd2 || out_icode !== 4'h0 || out_valid !== 1'b1) begin failures++; $display("FAIL halt_capture got=%b/%0h/%0h/%b exp=1/2/0/1", halted, out_stat, out_icode, out_valid); end
        drive(3'd1, 4'h6, 64'h1, 64'h2, 4'h1, 4'h2);
        tick();
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        checks++; if (out_stat !== 3'd2 || out_icode !== 4'h0 || out_val !== {64'hBB, 64'hAA}) begin failures++; $display("FAIL halt_freeze got=%0h/%0h/%0h exp=2/0/bb..aa", out_stat, out_icode, out_val); end
        checks++; if (stall_cnt !== 4'd3 || out_valid !== 1'b1 || halted !== 1'b1) begin failures++; $display("FAIL halt_cnt_valid got=%0d/%b/%b exp=3/1/1", stall_cnt, out_valid, halted); end
        pulse_reset();
        checks++; if (halted !== 1'b0 || out_stat !== 3'd1 || stall_cnt !== 4'd0) begin failures++; $display("FAIL halt_reset got=%b/%0h/%0d exp=0/1/0", halted, out_stat, stall_cnt); end
    endtask

    task automatic test_conflict_saturation();
        drive(3'd1, 4'h7, 64'h77, 64'h88, 4'h1, 4'h2);
        tick();
        stall = 1'b1;
        bubble = 1'b1;
        drive(3'd1, 4'h3, 64'h0, 64'h0, 4'h0, 4'h0);
        tick();
        bubble = 1'b0;
        checks++; if (out_icode !== 4'h7 || out_valid !== 1'b1 || out_val !== {64'h88, 64'h77}) begin failures++; $display("FAIL conflict_hold got=%0h/%b exp=7/1", out_icode, out_valid); end
        checks++; if (proto_err !== 1'b1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL conflict_flag got=%b/%0d exp=1/1", proto_err, stall_cnt); end
        stall = 1'b0;
        tick();
        checks++; if (proto_err !== 1'b1 || out_icode !== 4'h3) begin failures++; $display("FAIL conflict_sticky got=%b/%0h exp=1/3", proto_err, out_icode); end
        stall = 1'b1;
        repeat (20) tick();
        stall = 1'b0;
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL saturate got=%0d exp=15", stall_cnt); end
        checks++; if (out_icode !== 4'h3 || out_valid !== 1'b1) begin failures++; $display("FAIL saturate_hold got=%0h/%b exp=3/1", out_icode, out_valid); end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        drive(3'd1, 4'h9, 64'h99, 64'h66, 4'h5, 4'h6);
        tick();
        stall = 1'b1;
        repeat (7) tick();
        checks++; if (stall_cnt !== 4'd7 || out_icode !== 4'h9) begin failures++; $display("FAIL pre_async got=%0d/%0h exp=7/9", stall_cnt, out_icode); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (stall_cnt !== 4'd0 || out_icode !== 4'h1 || out_val !== 128'h0 || out_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%0h/%0h/%b exp=0/1/0/0", stall_cnt, out_icode, out_val, out_valid); end
        tick();
        checks++; if (stall_cnt !== 4'd0 || out_stat !== 3'd1 || {out_dstE, out_dstM} !== 8'hFF) begin failures++; $display("FAIL reset_held got=%0d/%0h/%0h exp=0/1/ff", stall_cnt, out_stat, {out_dstE, out_dstM}); end
        rst = 1'b0;
        stall = 1'b0;
        drive(3'd1, 4'hA, 64'h3, 64'h4, 4'h7, 4'h8);
        tick();
        checks++; if (out_icode !== 4'hA || out_val !== {64'h4, 64'h3} || out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_load got=%0h/%0h/%b exp=a/4..3/1", out_icode, out_val, out_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        bubble   = 1'b0;
        drive(3'd1, 4'h0, 64'h0, 64'h0, 4'h0, 4'h0);
        test_reset();
        test_load();
        test_stall();
        test_bubble();
        test_halt();
        test_conflict_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
